// File: rtl/sd_cmd_pkg.sv
// sd_cmd_pkg: command indices, R1 codes, arguments and state type shared by the SD command sequencer
package sd_cmd_pkg;

    localparam logic [5:0] CMD0   = 6'd0;
    localparam logic [5:0] CMD16  = 6'd16;
    localparam logic [5:0] CMD17  = 6'd17;
    localparam logic [5:0] CMD55  = 6'd55;
    localparam logic [5:0] ACMD41 = 6'd41;

    localparam logic [7:0] R1_READY = 8'h00;
    localparam logic [7:0] R1_IDLE  = 8'h01;

    localparam logic [31:0] ACMD41_HCS_ARG = 32'h4000_0000;
    localparam logic [31:0] BLOCK_LEN      = 32'd512;

    typedef enum logic [2:0] {
        ST_POWERUP,
        ST_ISSUE,
        ST_WAIT,
        ST_EVAL,
        ST_READY,
        ST_ERROR
    } state_t;

endpackage

// File: rtl/sd_wait_counter.sv
// sd_wait_counter: loadable down-counter that stops at zero and flags it
module sd_wait_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk400,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] loadValue,
    input  logic             enable,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    assign zero = (count == '0);

    // load has priority; otherwise count down while enabled, holding at zero
    always_ff @(posedge clk400) begin
        if (!reset)
            count <= '0;
        else if (load)
            count <= loadValue;
        else if (enable && !zero)
            count <= count - 1'b1;
    end

endmodule

// File: rtl/sd_command_sequencer.sv
// sd_command_sequencer: SPI-mode SD init sequence followed by CMD17 single-block reads
module sd_command_sequencer
    import sd_cmd_pkg::*;
#(
    parameter int POWERUP_CYCLES = 80,
    parameter int RETRY_MAX      = 255
) (
    input  logic        clk400,
    input  logic        reset,
    input  logic        readReq,
    input  logic [31:0] readAddr,
    output logic        readBusy,
    output logic        readDone,
    output logic        readError,
    output logic        initDone,
    output logic        initError,
    output logic [7:0]  lastResponse,
    output logic [5:0]  command,
    output logic [31:0] argument,
    output logic        startCommand,
    input  logic        commandDone,
    input  logic [7:0]  response
);

    // the load happens one edge into POWERUP and the zero test costs one more edge
    localparam logic [15:0] POWERUP_LOAD = 16'(POWERUP_CYCLES - 2);

    state_t      state;
    logic        armed;
    logic        waitZero;
    logic [7:0]  retry;
    logic [7:0]  retryNext;
    logic        exhausted;
    logic        go;
    logic        toReady;
    logic [5:0]  nextCommand;
    logic [31:0] nextArgument;

    sd_wait_counter #(.WIDTH(16)) powerupTimer (
        .clk400    (clk400),
        .reset     (reset),
        .load      (state == ST_POWERUP && !armed),
        .loadValue (POWERUP_LOAD),
        .enable    (state == ST_POWERUP),
        .zero      (waitZero)
    );

    assign retryNext = (retry == 8'hFF) ? retry : retry + 8'd1;
    assign exhausted = {24'd0, retryNext} >= 32'(RETRY_MAX);

    // decide where the R1 of the command just completed leads
    always_comb begin
        go           = 1'b0;
        toReady      = 1'b0;
        nextCommand  = CMD55;
        nextArgument = '0;
        case (command)
            CMD0:    go = (response == R1_IDLE);
            CMD55: begin
                go           = (response == R1_READY) || (response == R1_IDLE);
                nextCommand  = ACMD41;
                nextArgument = ACMD41_HCS_ARG;
            end
            ACMD41: begin
                go           = (response == R1_READY) || (response == R1_IDLE && !exhausted);
                nextCommand  = (response == R1_READY) ? CMD16 : CMD55;
                nextArgument = (response == R1_READY) ? BLOCK_LEN : '0;
            end
            CMD16:   toReady = (response == R1_READY);
            CMD17:   toReady = 1'b1;
            default: ;
        endcase
    end

    // sequencer FSM with all executor and host outputs registered
    always_ff @(posedge clk400) begin
        if (!reset) begin
            state        <= ST_POWERUP;
            armed        <= 1'b0;
            retry        <= '0;
            command      <= '0;
            argument     <= '0;
            startCommand <= 1'b0;
            readBusy     <= 1'b0;
            readDone     <= 1'b0;
            readError    <= 1'b0;
            initDone     <= 1'b0;
            initError    <= 1'b0;
            lastResponse <= 8'hFF;
        end else begin
            startCommand <= 1'b0;
            readDone     <= 1'b0;
            case (state)
                ST_POWERUP: begin
                    armed <= 1'b1;
                    if (armed && waitZero) begin
                        state        <= ST_ISSUE;
                        command      <= CMD0;
                        argument     <= '0;
                        startCommand <= 1'b1;
                        retry        <= '0;
                    end
                end
                ST_ISSUE: state <= ST_WAIT;
                ST_WAIT:  if (commandDone) state <= ST_EVAL;
                ST_EVAL: begin
                    lastResponse <= response;
                    if (command == ACMD41 && response == R1_IDLE)
                        retry <= retryNext;
                    if (command == CMD17) begin
                        readDone  <= 1'b1;
                        readError <= (response != R1_READY);
                        readBusy  <= 1'b0;
                    end
                    if (toReady) begin
                        state    <= ST_READY;
                        initDone <= 1'b1;
                    end else if (go) begin
                        state        <= ST_ISSUE;
                        command      <= nextCommand;
                        argument     <= nextArgument;
                        startCommand <= 1'b1;
                    end else begin
                        state     <= ST_ERROR;
                        initError <= 1'b1;
                        command   <= '0;
                        argument  <= '0;
                    end
                end
                ST_READY: if (readReq) begin
                    readError    <= 1'b0;
                    readBusy     <= 1'b1;
                    state        <= ST_ISSUE;
                    command      <= CMD17;
                    argument     <= readAddr;
                    startCommand <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
